// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 5-byte command frames (SYNC, ADDR, DATA_H,
// DATA_L, CHK) from the UART receiver byte stream and turns each frame with
// a good XOR checksum into a one-cycle register-write strobe. Bad checksums
// and inter-byte silence inside a frame are reported on o_err/o_err_code.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TO_W           = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid_n,
  output logic        o_wr_en,
  output logic [7:0]  o_addr,
  output logic [15:0] o_wdata,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DH, S_DL, S_CHK} state_e;

  // A zero timeout disables the watchdog entirely.
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  state_e          state_q, state_d;
  logic [7:0]      abuf_q, abuf_d;
  logic [7:0]      dh_q, dh_d;
  logic [7:0]      dl_q, dl_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  logic valid;
  assign valid = ~i_valid_n;

  // State and all registered outputs; synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      abuf_q  <= '0;
      dh_q    <= '0;
      dl_q    <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      abuf_q  <= abuf_d;
      dh_q    <= dh_d;
      dl_q    <= dl_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Next state: frame assembly, checksum, and inter-byte watchdog.
  always_comb begin
    state_d = state_q;
    abuf_d  = abuf_q;
    dh_d    = dh_q;
    dl_d    = dl_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (valid && i_data == SYNC_BYTE) state_d = S_ADDR;
      end
      S_ADDR: if (valid) begin abuf_d = i_data; state_d = S_DH;  end
      S_DH:   if (valid) begin dh_d   = i_data; state_d = S_DL;  end
      S_DL:   if (valid) begin dl_d   = i_data; state_d = S_CHK; end
      S_CHK: begin
        if (valid) begin
          state_d = S_IDLE;
          if (i_data == (abuf_q ^ dh_q ^ dl_q)) begin
            wr_en_d = 1'b1;
            addr_d  = abuf_q;
            wdata_d = {dh_q, dl_q};
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte on the firing cycle wins over the timeout.
    if (state_q != S_IDLE) begin
      if (valid) begin
        cnt_d = '0;
      end else if (TO_EN) begin
        if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: a byte-queue frame model predicts the outputs
// every cycle, and directed scenarios pin timing and values with literals.
module tb_uart_cmd_decoder;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid_n;
  logic        wr_en, err, busy;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(24)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid_n(valid_n),
    .o_wr_en(wr_en), .o_addr(addr), .o_wdata(wdata), .o_err(err),
    .o_err_code(code), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: a queue of the bytes of the frame in progress.
  logic [7:0]  frm[$];
  int          gap;
  logic        m_wr, m_err;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_code;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      frm.delete();
      gap <= 0; m_wr <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_code <= '0;
    end else begin
      m_wr <= 1'b0; m_err <= 1'b0;
      if (!valid_n) begin
        gap <= 0;
        if (frm.size() == 0) begin
          if (data == 8'hA5) frm.push_back(data);
        end else if (frm.size() == 4) begin
          if ((frm[1] ^ frm[2] ^ frm[3]) == data) begin
            m_wr <= 1'b1; m_addr <= frm[1]; m_wdata <= {frm[2], frm[3]};
          end else begin
            m_err <= 1'b1; m_code <= 2'b01;
          end
          frm.delete();
        end else begin
          frm.push_back(data);
        end
      end else if (frm.size() != 0) begin
        // gap idle cycles have already passed since the last byte
        if (gap + 1 == TO) begin
          m_err <= 1'b1; m_code <= 2'b10; frm.delete(); gap <= 0;
        end else begin
          gap <= gap + 1;
        end
      end
    end
  end

  // Compare process plus pulse bookkeeping for the literal checks.
  bit cmp_en = 1'b0;
  int wr_cnt = 0, err_cnt = 0, wr_cyc = 0, err_cyc = 0, prev_wr_cyc = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(frm.size() != 0));
      chk("addr", 32'(addr), 32'(m_addr));
      chk("wdata", 32'(wdata), 32'(m_wdata));
      chk("err_code", 32'(code), 32'(m_code));
      if (wr_en === 1'b1) begin wr_cnt++; prev_wr_cyc = wr_cyc; wr_cyc = cyc; end
      if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (wr_en === 1'b1 && err === 1'b1) chk("wr_err_overlap", 32'd1, 32'd0);
    end
  end

  int last_cyc;

  // Drive one byte for one cycle, then idle cycles; entered at posedge+2.
  task automatic send(input logic [7:0] b, input int idle);
    data = b; valid_n = 1'b0; last_cyc = cyc;
    @(posedge clk); #2;
    valid_n = 1'b1;
    repeat (idle) begin @(posedge clk); #2; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  int w0, e0, t12;

  initial begin
    rst_n = 1'b0; valid_n = 1'b1; data = '0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1; cmp_en = 1'b1;
    chk("reset_addr", 32'(addr), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Good frame, one byte every 20 cycles.
    w0 = wr_cnt; e0 = err_cnt;
    send(8'hA5, 19); send(8'h12, 19); send(8'hBE, 19); send(8'hEF, 19);
    send(8'h43, 0); t12 = last_cyc;
    idle(5);
    chk("good_wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("good_wr_latency", 32'(wr_cyc - t12), 32'd1);
    chk("good_addr", 32'(addr), 32'h12);
    chk("good_wdata", 32'(wdata), 32'hBEEF);
    chk("good_no_err", 32'(err_cnt - e0), 32'd0);

    // Bad checksum keeps the previous address/data.
    w0 = wr_cnt; e0 = err_cnt;
    send(8'hA5, 19); send(8'h12, 19); send(8'hBE, 19); send(8'hEF, 19);
    send(8'h44, 0); t12 = last_cyc;
    idle(5);
    chk("bad_err_count", 32'(err_cnt - e0), 32'd1);
    chk("bad_err_latency", 32'(err_cyc - t12), 32'd1);
    chk("bad_err_code", 32'(code), 32'h1);
    chk("bad_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("bad_addr_held", 32'(addr), 32'h12);
    chk("bad_wdata_held", 32'(wdata), 32'hBEEF);

    // Garbage ahead of a frame is ignored silently.
    w0 = wr_cnt; e0 = err_cnt;
    send(8'h00, 3); send(8'hFF, 3); send(8'h5A, 3);
    chk("garbage_idle", 32'(busy), 32'h0);
    send(8'hA5, 3); send(8'h34, 3); send(8'h00, 3); send(8'h01, 3); send(8'h35, 5);
    chk("garbage_wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("garbage_no_err", 32'(err_cnt - e0), 32'd0);
    chk("garbage_addr", 32'(addr), 32'h34);
    chk("garbage_wdata", 32'(wdata), 32'h0001);

    // Timeout: silence after the second byte.
    e0 = err_cnt;
    send(8'hA5, 3); send(8'h12, 0); t12 = last_cyc;
    idle(60);
    chk("to_err_count", 32'(err_cnt - e0), 32'd1);
    chk("to_err_latency", 32'(err_cyc - t12), 32'd51);
    chk("to_err_code", 32'(code), 32'h2);
    chk("to_busy", 32'(busy), 32'h0);

    // Byte on the firing cycle wins over the timeout.
    w0 = wr_cnt; e0 = err_cnt;
    send(8'hA5, 3); send(8'h12, 49); t12 = last_cyc;
    send(8'hBE, 0);
    chk("to_edge_spacing", 32'(last_cyc - t12), 32'd50);
    send(8'hEF, 0); send(8'h43, 5);
    chk("to_edge_no_err", 32'(err_cnt - e0), 32'd0);
    chk("to_edge_wr", 32'(wr_cnt - w0), 32'd1);

    // Reset mid-frame discards the partial frame.
    w0 = wr_cnt;
    send(8'hA5, 1); send(8'h12, 1); send(8'hBE, 1);
    rst_n = 1'b0; @(posedge clk); #2; rst_n = 1'b1;
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    send(8'hEF, 1); send(8'h43, 5);
    chk("rst_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("rst_ignored", 32'(busy), 32'h0);

    // Back-to-back frames on consecutive cycles.
    w0 = wr_cnt; e0 = err_cnt;
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h02, 0); send(8'h03, 0);
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0); send(8'h03, 0); send(8'h01, 5);
    chk("b2b_wr_count", 32'(wr_cnt - w0), 32'd2);
    chk("b2b_spacing", 32'(wr_cyc - prev_wr_cyc), 32'd5);
    chk("b2b_addr", 32'(addr), 32'h02);
    chk("b2b_wdata", 32'(wdata), 32'h0003);
    chk("b2b_no_err", 32'(err_cnt - e0), 32'd0);

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Byte-stream frame decoder that sits directly downstream of the UART receiver.
- Consumes the receiver's 8-bit data and its active-low, one-cycle valid strobe.
- Assembles fixed 5-byte command frames (SYNC, ADDR, DATA_H, DATA_L, CHK) and issues a single-cycle register-write strobe to the chip's register bank when a frame's checksum matches.
- Reports checksum and inter-byte timeout errors.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 100000: maximum number of clock cycles allowed between bytes inside a frame; 0 disables the timeout.
- TO_W, 24: width of the timeout counter. TIMEOUT_CYCLES must fit in TO_W bits.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_data  in  8  received byte; sampled only when i_valid_n=0.
- i_valid_n  in  1  byte-valid strobe, active-low; every cycle it is low counts as one byte.
- o_wr_en  out  1  register-write strobe, one cycle high.
- o_addr  out  8  write address; held until the next successful frame.
- o_wdata  out  16  write data {DATA_H, DATA_L}; held until the next successful frame.
- o_err  out  1  error strobe, one cycle high.
- o_err_code  out  2  error cause: 2'b01 checksum, 2'b10 timeout; held until the next error.
- o_busy  out  1  high while a frame is in progress (state != S_IDLE).

Behaviour:
- Reset (synchronous, i_rst_n=0 at a rising edge):
  - State goes to S_IDLE.
  - o_wr_en=0, o_addr=0, o_wdata=0, o_err=0, o_err_code=0, o_busy=0.
  - Timeout counter=0; partial-frame registers cleared.
  - Reset mid-frame discards the partial frame; no strobe is generated.
- State machine: S_IDLE -> S_ADDR -> S_DH -> S_DL -> S_CHK -> S_IDLE. A transition happens only on a cycle with i_valid_n=0, except for timeout.
  - S_IDLE: a byte equal to SYNC_BYTE moves to S_ADDR. Any other byte is silently ignored, with no error.
  - S_ADDR, S_DH, S_DL: capture the byte into the address, data-high and data-low holding registers respectively. A SYNC_BYTE value here is plain data; there is no resync.
  - S_CHK: compare the byte with ADDR^DATA_H^DATA_L, then return to S_IDLE.
    - Match: o_addr and o_wdata update and o_wr_en=1 in the next cycle (latency 1 cycle from the CHK valid cycle).
    - Mismatch: o_err=1 and o_err_code=2'b01 in the next cycle. o_addr and o_wdata are unchanged; no o_wr_en.
- o_wr_en and o_err are single-cycle pulses; both are registered outputs. They are never high in the same cycle.
- Timeout:
  - The counter is cleared on every accepted byte and held at 0 in S_IDLE.
  - In any other state it increments on each cycle with i_valid_n=1.
  - When the counter equals TIMEOUT_CYCLES-1 and no byte is present, the next edge forces S_IDLE, sets o_err=1 and sets o_err_code=2'b10.
  - Net effect: o_err rises TIMEOUT_CYCLES+1 cycles after the last byte's valid cycle.
- Simultaneous events: a byte arriving on the cycle the timeout would fire wins. It is accepted normally and no timeout is raised.
- Back-to-back frames: a SYNC_BYTE may arrive on the cycle immediately after CHK, with no idle gap. Bytes on consecutive cycles are all accepted.
- o_busy is combinational from state: 1 in S_ADDR, S_DH, S_DL and S_CHK.

Test Plan:
- Good frame: bytes A5,12,BE,EF,43 (one valid per 20 cycles) -> o_wr_en=1 for exactly one cycle, 1 cycle after the 43 strobe; o_addr=8'h12; o_wdata=16'hBEEF; o_err stays 0; o_busy falls in the same cycle.
- Bad checksum: A5,12,BE,EF,44 -> o_err=1 for one cycle with o_err_code=2'b01; no o_wr_en; o_addr and o_wdata keep their previous values.
- Garbage/resync: 00,FF,5A, then A5,34,00,01,35 -> no error during the garbage; a single o_wr_en with o_addr=8'h34 and o_wdata=16'h0001.
- Timeout (TIMEOUT_CYCLES=50):
  - A5,12, then silence -> o_err=1 with code 2'b10 exactly 51 cycles after the 12 strobe; o_busy=0.
  - Repeat with the third byte arriving 50 cycles after 12 -> no error, and the frame completes normally.
- Reset mid-frame: A5,12,BE, then i_rst_n=0 for 1 cycle, then EF,43 -> all outputs 0 after reset; EF and 43 are ignored; no strobe.
- Back-to-back: A5,01,00,02,03,A5,02,00,03,01 on consecutive cycles -> two o_wr_en pulses 5 cycles apart (addr 01/data 0002, then addr 02/data 0003); no error.
